oh_cellchar2: RTL and testbench

// Sequential characterization driver for 2-input standard cells (oh_nand2 and peers). It sits directly upstream of the cell.
// It drives the cell's a/b inputs through a Gray-ordered vector sweep and samples the cell's z output after a settle window.
// It checks z against a programmable truth table and reports pass/fail, error count and first failing vector.

---
 rtl/oh_cellchar2.sv | 173 +++++++++++++++++
 tb/tb_oh_cellchar2.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/oh_cellchar2.sv
// Characterization driver for 2-input cells: Gray-ordered a/b sweep, settle wait, synchronized
// z sampling against a programmable truth table, with error count and first-failure capture.
module oh_cellchar2 #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned LW     = 16,
  parameter int unsigned CW     = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          abort,
  input  logic [LW-1:0] loops,
  output logic          a_out,
  output logic          b_out,
  input  logic          z_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] errcount,
  output logic [1:0]    fail_vec,
  output logic          fail_valid
);

  localparam int unsigned SW = $clog2(SETTLE + 2);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StApply  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StSample = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]    r_state, w_state_d;
  logic [SW-1:0] r_wcnt, w_wcnt_d;
  logic [LW-1:0] r_loops, w_loops_d;
  logic [1:0]    r_idx, w_idx_d;
  logic [1:0]    r_vec, w_vec_d;
  logic          r_busy, w_busy_d;
  logic          r_done, w_done_d;
  logic          r_pass, w_pass_d;
  logic [CW-1:0] r_err, w_err_d;
  logic [1:0]    r_fail_vec, w_fail_vec_d;
  logic          r_fail_valid, w_fail_valid_d;
  logic [1:0]    r_zsync;

  logic w_active;
  logic w_mismatch;

  assign w_active   = (r_state == StApply) || (r_state == StWait) || (r_state == StSample);
  assign w_mismatch = (r_zsync[1] != TRUTH[r_vec]);

  always_comb begin
    w_state_d      = r_state;
    w_wcnt_d       = r_wcnt;
    w_loops_d      = r_loops;
    w_idx_d        = r_idx;
    w_vec_d        = r_vec;
    w_busy_d       = r_busy;
    w_done_d       = r_done;
    w_pass_d       = r_pass;
    w_err_d        = r_err;
    w_fail_vec_d   = r_fail_vec;
    w_fail_valid_d = r_fail_valid;

    if (w_active && abort) begin
      // Abort keeps the partial error record; only the verdict is forced.
      w_state_d = StDone;
      w_busy_d  = 1'b0;
      w_done_d  = 1'b1;
      w_pass_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start && !abort) begin
            w_err_d        = '0;
            w_fail_vec_d   = '0;
            w_fail_valid_d = 1'b0;
            if (loops == '0) begin
              w_state_d = StDone;
              w_done_d  = 1'b1;
              w_pass_d  = 1'b1;
              w_busy_d  = 1'b0;
            end else begin
              w_state_d = StApply;
              w_loops_d = loops;
              w_idx_d   = 2'd0;
              w_done_d  = 1'b0;
              w_pass_d  = 1'b0;
              w_busy_d  = 1'b1;
            end
          end
        end
        StApply: begin
          w_vec_d   = {r_idx[1], r_idx[1] ^ r_idx[0]};
          w_wcnt_d  = SW'(SETTLE + 1);
          w_state_d = StWait;
        end
        StWait: begin
          // Covers settle time plus the two synchronizer stages.
          if (r_wcnt == '0) begin
            w_state_d = StSample;
          end else begin
            w_wcnt_d = r_wcnt - SW'(1);
          end
        end
        StSample: begin
          if (w_mismatch) begin
            if (!(&r_err)) begin
              w_err_d = r_err + CW'(1);
            end
            if (!r_fail_valid) begin
              w_fail_vec_d   = r_vec;
              w_fail_valid_d = 1'b1;
            end
          end
          w_idx_d   = r_idx + 2'd1;
          w_state_d = StApply;
          if (r_idx == 2'd3) begin
            if (r_loops == LW'(1)) begin
              w_state_d = StDone;
              w_busy_d  = 1'b0;
              w_done_d  = 1'b1;
              w_pass_d  = (r_err == '0) && !w_mismatch;
            end else begin
              w_loops_d = r_loops - LW'(1);
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= StIdle;
      r_wcnt       <= '0;
      r_loops      <= '0;
      r_idx        <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
      r_zsync      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_wcnt       <= w_wcnt_d;
      r_loops      <= w_loops_d;
      r_idx        <= w_idx_d;
      r_vec        <= w_vec_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_pass       <= w_pass_d;
      r_err        <= w_err_d;
      r_fail_vec   <= w_fail_vec_d;
      r_fail_valid <= w_fail_valid_d;
      r_zsync      <= {r_zsync[0], z_in};
    end
  end

  assign a_out      = r_vec[1];
  assign b_out      = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign errcount   = r_err;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_oh_cellchar2.sv
// Directed bench for oh_cellchar2: NAND model, stuck-at faults, saturation, loops=0, abort, reset.
module tb_oh_cellchar2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] loops = '0;
  logic [1:0]  zmode = 2'd0;  // 0: NAND cell, 1: stuck-at-1, 2: stuck-at-0

  logic       a_out, b_out, busy, done, pass, fail_valid, z_in;
  logic [7:0] errcount;
  logic [1:0] fail_vec;

  logic       d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_fail_valid;
  logic [1:0] d2_errcount;
  logic [1:0] d2_fail_vec;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc;

  assign z_in = (zmode == 2'd0) ? ~(a_out & b_out) : (zmode == 2'd1);

  always #5 clk = ~clk;

  oh_cellchar2 #(.TRUTH(4'b0111), .SETTLE(4), .LW(16), .CW(8)) u_dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort), .loops(loops),
    .a_out(a_out), .b_out(b_out), .z_in(z_in), .busy(busy), .done(done), .pass(pass),
    .errcount(errcount), .fail_vec(fail_vec), .fail_valid(fail_valid)
  );

  // Narrow counter, cell output stuck at 0.
  oh_cellchar2 #(.TRUTH(4'b0111), .SETTLE(4), .LW(16), .CW(2)) u_dut2 (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort), .loops(loops),
    .a_out(d2_a), .b_out(d2_b), .z_in(1'b0), .busy(d2_busy), .done(d2_done), .pass(d2_pass),
    .errcount(d2_errcount), .fail_vec(d2_fail_vec), .fail_valid(d2_fail_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge that accepts start counts as cycle 1.
  task automatic start_run(input logic [15:0] l);
    loops = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic run_to_done(input string tag);
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    #2;
    check("rst_ab", {a_out, b_out}, 0);
    check("rst_flags", {busy, done, pass, fail_valid}, 0);
    check("rst_err", {errcount, fail_vec}, 0);
    #10 nreset = 1'b1;
    tick();

    // T1: ideal NAND, one sweep; stray start mid-run must be ignored.
    zmode = 2'd0;
    start_run(16'd1);
    check("t1_busy", {busy, done}, 2'b10);
    while (!done && cyc < 200) begin
      start = (cyc == 19);
      tick();
      cyc++;
      if (cyc == 6)  check("t1_vec0", {a_out, b_out}, 2'b00);
      if (cyc == 14) check("t1_vec1", {a_out, b_out}, 2'b01);
      if (cyc == 22) check("t1_vec2", {a_out, b_out}, 2'b11);
      if (cyc == 30) check("t1_vec3", {a_out, b_out}, 2'b10);
    end
    start = 1'b0;
    check("t1_latency", cyc, 33);
    check("t1_result", {busy, pass, fail_valid}, 3'b010);
    check("t1_err", errcount, 0);

    // start together with abort in DONE: nothing happens.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("sa_hold", {busy, done, pass}, 3'b011);

    // T2: stuck-at-1 fails only vector 11.
    zmode = 2'd1;
    start_run(16'd3);
    run_to_done("t2");
    check("t2_latency", cyc, 97);
    check("t2_err", errcount, 3);
    check("t2_fail", {fail_valid, fail_vec, pass}, 4'b1110);

    // T4: loops=0 completes immediately with no drive change.
    start_run(16'd0);
    check("t4_result", {done, pass, busy}, 3'b110);
    check("t4_err", {errcount, fail_valid}, 0);
    tick();
    tick();
    check("t4_ab", {a_out, b_out, busy}, 3'b100);

    // T3: narrow counter saturates; NAND instance passes alongside.
    zmode = 2'd0;
    start_run(16'd4);
    run_to_done("t3");
    check("t3_latency", cyc, 129);
    check("t3_d2_err", d2_errcount, 3);
    check("t3_d2_fail", {d2_done, d2_pass, d2_fail_valid, d2_fail_vec}, 5'b10100);
    check("t3_d1", {pass, errcount}, 9'h100);

    // T5: abort during WAIT of the second vector after one mismatch at 00.
    zmode = 2'd2;
    start_run(16'd1);
    while (cyc < 12) begin
      tick();
      cyc++;
    end
    check("t5_pre", {busy, a_out, b_out}, 3'b101);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort", {busy, done, pass}, 3'b010);
    check("t5_keep", {errcount, fail_valid, fail_vec, a_out, b_out}, {8'd1, 1'b1, 2'b00, 2'b01});
    zmode = 2'd0;
    start_run(16'd1);
    check("t5_clear", {errcount, fail_valid, done, busy}, 11'b1);
    run_to_done("t5");
    check("t5_rerun", {cyc[7:0], pass}, {8'd33, 1'b1});

    // T6: asynchronous reset between edges mid-run.
    start_run(16'd2);
    repeat (10) tick();
    check("t6_pre", {busy, a_out, b_out}, 3'b101);
    #3 nreset = 1'b0;
    #1;
    check("t6_rst_ab", {a_out, b_out, busy, done, pass}, 0);
    check("t6_rst_err", {errcount, fail_vec, fail_valid}, 0);
    #2 nreset = 1'b1;
    tick();
    check("t6_idle", {busy, done}, 0);
    start_run(16'd1);
    run_to_done("t6");
    check("t6_rerun", {cyc[7:0], pass, errcount}, {8'd33, 1'b1, 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
